lifo_fifo_buf: RTL and testbench
================================

LIFO_FIFO_BUF -- requirements
Module: lifo_fifo_buf

Interface
REQ-001 Parameter DATA_W, default 6, data word width in bits (1..32).
REQ-002 Parameter DEPTH, default 16, number of storage entries (power of two, 2..256).
REQ-003 Parameter EDGE_MODE, default 1: 1 = write/read act on rising edge; 0 = act every cycle high.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mode  input  1  0 = LIFO (stack), 1 = FIFO (queue).
REQ-007 data_in  input  DATA_W  word to store.
REQ-008 write  input  1  store request (debounced level).
REQ-009 read  input  1  remove request (debounced level).
REQ-010 clr_err  input  1  clears sticky error flags.
REQ-011 data_out  output  DATA_W  last word removed, registered.
REQ-012 peek  output  DATA_W  word the next read will return; 0 when empty.
REQ-013 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-014 empty_flag, full_flag, loading_flag  output  1 each  count==0 / count==DEPTH / 0<count<DEPTH.
REQ-015 ovf_err, unf_err  output  1 each  sticky overflow / underflow.
REQ-016 mode_active  output  1  mode currently in effect.

Function
REQ-017 With EDGE_MODE=1, wr_req/rd_req = input high now and low on the previous clk sample; with EDGE_MODE=0, wr_req/rd_req = input level.
REQ-018 Operations commit on the clk edge where the request is sampled; data_out, count, flags, and peek reflect the operation after that edge (1-cycle latency).
REQ-019 LIFO read returns the most recently stored valid word; FIFO read returns the oldest.
REQ-020 Write alone with count<DEPTH: store data_in, count+1.
REQ-021 Write alone when full: ignore the write, set ovf_err, leave contents unchanged.
REQ-022 Read alone with count>0: data_out <= returned word, count-1.
REQ-023 Read alone when empty: set unf_err, leave data_out and count unchanged.
REQ-024 Simultaneous write+read, LIFO, count>0: data_out <= top, top replaced by data_in, count unchanged.
REQ-025 Simultaneous write+read, FIFO, count>0 (including full): data_out <= head, data_in enqueued, count unchanged, no ovf_err.
REQ-026 Simultaneous write+read when empty, either mode: perform write only; no unf_err.
REQ-027 FIFO read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; the LIFO stack pointer never wraps.
REQ-028 mode_active loads mode only on a cycle where count==0 with no write request; mode changes at any other time are ignored until empty.
REQ-029 clr_err clears ovf_err/unf_err; an error event in the same cycle wins (flag stays 1).
REQ-030 Exactly one of empty_flag, loading_flag, full_flag is high at all times.

Reset
REQ-031 rst_n low asynchronously forces count=0, pointers=0, data_out=0, ovf_err=unf_err=0, mode_active=0, and edge-detect history=1 (no spurious edge when held buttons release reset).
REQ-032 Storage array contents need not be reset; peek = 0 while empty.
REQ-033 Reset asserted mid-operation discards the in-flight request; the first post-reset operation requires a fresh rising edge.

Structure
REQ-034 Shared package lifo_fifo_pkg holds MODE_LIFO/MODE_FIFO constants and a count-width function.
REQ-035 One sub-module, req_edge (parametrised by EDGE_MODE), instantiated twice for write and read.
REQ-036 Storage is a single DEPTH x DATA_W register array, with no vendor primitives.

Verification (DATA_W=6, DEPTH=4)
REQ-037 LIFO: write 5, 9, 17, then read x3 -> data_out 17, 9, 5; count 3->0; empty_flag=1 after the final read.
REQ-038 FIFO: write 1, 2, 3, 4 (full_flag=1), write 7 -> ovf_err=1, count=4; read x4 -> 1, 2, 3, 4; wrap then write 8, read -> 8.
REQ-039 Empty read -> unf_err=1, data_out held; clr_err -> 0; write held high 10 cycles (EDGE_MODE=1) -> count=1 only.
REQ-040 Simultaneous write 33 + read at count=2, LIFO top=12 -> data_out=12, peek=33, count=2; FIFO full with head=1 -> data_out=1, count=4, no ovf_err.
REQ-041 mode toggled to 1 while count=2 -> mode_active stays 0 until both reads complete, then becomes 1.
REQ-042 rst_n pulsed low mid-sequence with write held high -> all outputs 0, no store after release until write drops and rises again.

Source files
------------

// File: rtl/lifo_fifo_pkg.sv
// Shared constants and helpers for the LIFO/FIFO buffer.
//   MODE_LIFO / MODE_FIFO : encodings of the mode input and mode_active output
//   cnt_w()               : width of an occupancy counter that can hold 0..depth
package lifo_fifo_pkg;

    localparam logic MODE_LIFO = 1'b0;
    localparam logic MODE_FIFO = 1'b1;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_fifo_buf_req_edge.sv
// Request qualifier for one debounced push-button level.
//   clk, rst_n : clock, async active-low reset
//   level_in   : debounced request level
//   req_c      : combinational request (rising edge or level, per EDGE_MODE)
module req_edge #(
    parameter int unsigned EDGE_MODE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level_in,
    output logic req_c
);

    logic hist_q;
    logic hist_d;

    always_comb hist_d = level_in;

    // History resets high so a button held through reset does not fire on release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q <= 1'b1;
        else        hist_q <= hist_d;
    end

    assign req_c = (EDGE_MODE != 0) ? (level_in & ~hist_q) : level_in;

endmodule

// File: rtl/lifo_fifo_buf.sv
// Dual-mode storage buffer: stack (LIFO) or queue (FIFO) over one register array.
//   clk, rst_n      : clock, async active-low reset
//   mode            : requested mode (0 LIFO, 1 FIFO), adopted only while empty
//   data_in         : word to store
//   write, read     : store / remove request levels
//   clr_err         : clears sticky error flags
//   data_out        : last word removed (registered)
//   peek            : word the next read returns, 0 when empty
//   count           : occupancy
//   empty/full/loading_flag : occupancy status, exactly one high
//   ovf_err/unf_err : sticky overflow / underflow
//   mode_active     : mode currently in effect
module lifo_fifo_buf
    import lifo_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 6,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned EDGE_MODE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      write,
    input  logic                      read,
    input  logic                      clr_err,
    output logic [DATA_W-1:0]         data_out,
    output logic [DATA_W-1:0]         peek,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      empty_flag,
    output logic                      full_flag,
    output logic                      loading_flag,
    output logic                      ovf_err,
    output logic                      unf_err,
    output logic                      mode_active
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic wr_req_c;
    logic rd_req_c;

    req_edge #(.EDGE_MODE(EDGE_MODE)) u_wr_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .level_in (write),
        .req_c    (wr_req_c)
    );

    req_edge #(.EDGE_MODE(EDGE_MODE)) u_rd_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .level_in (read),
        .req_c    (rd_req_c)
    );

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              mode_q, mode_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              loading_q, loading_d;

    logic              ovf_set_c;
    logic              unf_set_c;
    logic              is_empty_c;
    logic              is_full_c;
    logic [AW-1:0]     top_idx_c;
    logic [AW-1:0]     push_idx_c;
    logic [DATA_W-1:0] pop_word_c;

    // Stack grows from index 0; its pointer is the occupancy itself, so it never wraps
    assign is_empty_c = (count_q == '0);
    assign is_full_c  = (count_q == FULL_CNT);
    assign top_idx_c  = AW'(count_q - CW'(1));
    assign push_idx_c = AW'(count_q);
    assign pop_word_c = (mode_q == MODE_FIFO) ? mem_q[rd_ptr_q] : mem_q[top_idx_c];

    // Next-state for storage, pointers, data_out and error flags
    always_comb begin
        mem_d      = mem_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        ovf_set_c  = 1'b0;
        unf_set_c  = 1'b0;

        if (wr_req_c && rd_req_c && !is_empty_c) begin
            // Swap: pop and push in one edge, occupancy unchanged
            data_out_d = pop_word_c;
            if (mode_q == MODE_FIFO) begin
                mem_d[wr_ptr_q] = data_in;
                wr_ptr_d        = wr_ptr_q + AW'(1);
                rd_ptr_d        = rd_ptr_q + AW'(1);
            end else begin
                mem_d[top_idx_c] = data_in;
            end
        end else if (wr_req_c) begin
            // Also covers write+read on empty: the read is dropped silently
            if (is_full_c) begin
                ovf_set_c = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
                if (mode_q == MODE_FIFO) begin
                    mem_d[wr_ptr_q] = data_in;
                    wr_ptr_d        = wr_ptr_q + AW'(1);
                end else begin
                    mem_d[push_idx_c] = data_in;
                end
            end
        end else if (rd_req_c) begin
            if (is_empty_c) begin
                unf_set_c = 1'b1;
            end else begin
                data_out_d = pop_word_c;
                count_d    = count_q - CW'(1);
                if (mode_q == MODE_FIFO) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
            end
        end

        // A new error event outranks a simultaneous clear
        ovf_d = ovf_set_c | (ovf_q & ~clr_err);
        unf_d = unf_set_c | (unf_q & ~clr_err);

        // Mode is only switched while idle-empty so pointers stay consistent
        mode_d = (is_empty_c && !wr_req_c) ? mode : mode_q;

        empty_d   = (count_d == '0);
        full_d    = (count_d == FULL_CNT);
        loading_d = !empty_d && !full_d;
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_out_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            mode_q     <= MODE_LIFO;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            loading_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_out_q <= data_out_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            mode_q     <= mode_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            loading_q  <= loading_d;
        end
    end

    // Storage array, not reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign data_out     = data_out_q;
    assign peek         = is_empty_c ? '0 : pop_word_c;
    assign count        = count_q;
    assign empty_flag   = empty_q;
    assign full_flag    = full_q;
    assign loading_flag = loading_q;
    assign ovf_err      = ovf_q;
    assign unf_err      = unf_q;
    assign mode_active  = mode_q;

endmodule

// File: tb/tb_lifo_fifo_buf.sv
// Self-checking bench for lifo_fifo_buf (DATA_W=6, DEPTH=4, EDGE_MODE=1).
module tb_lifo_fifo_buf;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic [5:0] data_in = '0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic       clr_err = 1'b0;
    logic [5:0] data_out;
    logic [5:0] peek;
    logic [2:0] count;
    logic       empty_flag, full_flag, loading_flag;
    logic       ovf_err, unf_err, mode_active;

    int errors = 0;
    int checks = 0;

    lifo_fifo_buf #(.DATA_W(6), .DEPTH(4), .EDGE_MODE(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode         (mode),
        .data_in      (data_in),
        .write        (write),
        .read         (read),
        .clr_err      (clr_err),
        .data_out     (data_out),
        .peek         (peek),
        .count        (count),
        .empty_flag   (empty_flag),
        .full_flag    (full_flag),
        .loading_flag (loading_flag),
        .ovf_err      (ovf_err),
        .unf_err      (unf_err),
        .mode_active  (mode_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       w;
        logic       r;
        logic       m;
        logic       c;
        logic [5:0] din;
        int         edout;
        int         ecnt;
        int         epeek;
        int         eovf;
        int         eunf;
        int         ema;
    } vec_t;

    vec_t tv [28];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int edout, input int ecnt, input int epeek,
                               input int eovf, input int eunf, input int ema);
        chk({tag, " data_out"}, 32'(data_out), edout);
        chk({tag, " count"}, 32'(count), ecnt);
        chk({tag, " peek"}, 32'(peek), epeek);
        chk({tag, " empty"}, 32'(empty_flag), (ecnt == 0) ? 1 : 0);
        chk({tag, " full"}, 32'(full_flag), (ecnt == 4) ? 1 : 0);
        chk({tag, " loading"}, 32'(loading_flag), (ecnt > 0 && ecnt < 4) ? 1 : 0);
        chk({tag, " ovf"}, 32'(ovf_err), eovf);
        chk({tag, " unf"}, 32'(unf_err), eunf);
        chk({tag, " mode_active"}, 32'(mode_active), ema);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic w, input logic r, input logic m, input logic c, input logic [5:0] din);
        write   = w;
        read    = r;
        mode    = m;
        clr_err = c;
        data_in = din;
        tick();
    endtask

    task automatic idle();
        write   = 1'b0;
        read    = 1'b0;
        clr_err = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        write   = 1'b0;
        read    = 1'b0;
        clr_err = 1'b0;
        mode    = 1'b0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        //          w  r  m  c  din   dout cnt peek ovf unf ma
        tv[0]  = '{1, 0, 0, 0, 6'd5,   0,  1,  5,  0,  0,  0};
        tv[1]  = '{1, 0, 0, 0, 6'd9,   0,  2,  9,  0,  0,  0};
        tv[2]  = '{1, 0, 0, 0, 6'd17,  0,  3, 17,  0,  0,  0};
        tv[3]  = '{0, 1, 0, 0, 6'd0,  17,  2,  9,  0,  0,  0};
        tv[4]  = '{0, 1, 0, 0, 6'd0,   9,  1,  5,  0,  0,  0};
        tv[5]  = '{0, 1, 0, 0, 6'd0,   5,  0,  0,  0,  0,  0};
        tv[6]  = '{0, 1, 0, 0, 6'd0,   5,  0,  0,  0,  1,  0};
        tv[7]  = '{0, 0, 0, 1, 6'd0,   5,  0,  0,  0,  0,  0};
        tv[8]  = '{0, 0, 1, 0, 6'd0,   5,  0,  0,  0,  0,  1};
        tv[9]  = '{1, 0, 1, 0, 6'd1,   5,  1,  1,  0,  0,  1};
        tv[10] = '{1, 0, 1, 0, 6'd2,   5,  2,  1,  0,  0,  1};
        tv[11] = '{1, 0, 1, 0, 6'd3,   5,  3,  1,  0,  0,  1};
        tv[12] = '{1, 0, 1, 0, 6'd4,   5,  4,  1,  0,  0,  1};
        tv[13] = '{1, 0, 1, 0, 6'd7,   5,  4,  1,  1,  0,  1};
        tv[14] = '{0, 1, 1, 0, 6'd0,   1,  3,  2,  1,  0,  1};
        tv[15] = '{0, 1, 1, 0, 6'd0,   2,  2,  3,  1,  0,  1};
        tv[16] = '{0, 1, 1, 0, 6'd0,   3,  1,  4,  1,  0,  1};
        tv[17] = '{0, 1, 1, 0, 6'd0,   4,  0,  0,  1,  0,  1};
        tv[18] = '{1, 0, 1, 0, 6'd8,   4,  1,  8,  1,  0,  1};
        tv[19] = '{0, 1, 1, 0, 6'd0,   8,  0,  0,  1,  0,  1};
        tv[20] = '{1, 1, 1, 0, 6'd50,  8,  1, 50,  1,  0,  1};
        tv[21] = '{0, 1, 1, 0, 6'd0,  50,  0,  0,  1,  0,  1};
        tv[22] = '{0, 0, 1, 1, 6'd0,  50,  0,  0,  0,  0,  1};
        tv[23] = '{1, 0, 1, 0, 6'd1,  50,  1,  1,  0,  0,  1};
        tv[24] = '{1, 0, 1, 0, 6'd2,  50,  2,  1,  0,  0,  1};
        tv[25] = '{1, 0, 1, 0, 6'd3,  50,  3,  1,  0,  0,  1};
        tv[26] = '{1, 0, 1, 0, 6'd4,  50,  4,  1,  0,  0,  1};
        tv[27] = '{1, 1, 1, 0, 6'd33,  1,  4,  2,  0,  0,  1};

        do_reset();
        check_state("reset", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 28; i++) begin
            op(tv[i].w, tv[i].r, tv[i].m, tv[i].c, tv[i].din);
            check_state($sformatf("vec%0d", i), tv[i].edout, tv[i].ecnt, tv[i].epeek,
                        tv[i].eovf, tv[i].eunf, tv[i].ema);
            idle();
        end

        // LIFO swap: top replaced, count unchanged
        do_reset();
        check_state("reset2", 0, 0, 0, 0, 0, 0);
        op(1, 0, 0, 0, 6'd7);
        idle();
        op(1, 0, 0, 0, 6'd12);
        check_state("lifo_w12", 0, 2, 12, 0, 0, 0);
        idle();
        op(1, 1, 0, 0, 6'd33);
        check_state("lifo_swap", 12, 2, 33, 0, 0, 0);
        idle();

        // Mode request while non-empty is deferred until drained
        mode = 1'b1;
        idle();
        idle();
        check_state("mode_hold", 12, 2, 33, 0, 0, 0);
        op(0, 1, 1, 0, 6'd0);
        check_state("mode_rd1", 33, 1, 7, 0, 0, 0);
        idle();
        op(0, 1, 1, 0, 6'd0);
        check_state("mode_rd2", 7, 0, 0, 0, 0, 0);
        idle();
        check_state("mode_switch", 7, 0, 0, 0, 0, 1);

        // Held write stores exactly once
        write   = 1'b1;
        data_in = 6'd3;
        for (int k = 0; k < 10; k++) tick();
        check_state("held_write", 7, 1, 3, 0, 0, 1);
        write = 1'b0;
        tick();

        // Async reset mid-sequence with write held high
        write   = 1'b1;
        data_in = 6'd20;
        tick();
        check_state("pre_rst", 7, 2, 3, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("rst_async", 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check_state("rst_hold", 0, 0, 0, 0, 0, 1);
        write = 1'b0;
        tick();
        write = 1'b1;
        tick();
        check_state("rst_fresh", 0, 1, 20, 0, 0, 1);
        write = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
